// File: rtl/alu_seq.sv
// alu_seq: registered ALU with a single-cycle path for ADD/SUB/logic/shift ops
// and an iterative shift-add multiplier. An NZCV flag register updates on
// completion when setflags was set at launch. start/busy/done handshake.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alucontrol,
  input  logic             setflags,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       aluflags,
  output logic             busy,
  output logic             done
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_ORR = 4'd3;
  localparam logic [3:0] OP_EOR = 4'd4;
  localparam logic [3:0] OP_LSL = 4'd5;
  localparam logic [3:0] OP_LSR = 4'd6;
  localparam logic [3:0] OP_ASR = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, mcand, mplier, mul_add;
  logic [SHW-1:0]   cnt;
  logic             mul_sf;

  logic             go_alu, go_mul, mul_last;
  logic             sub;
  logic [WIDTH-1:0] bop;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   sh, lsl_idx, rs_idx;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v, alu_valid;

  assign go_alu   = (state == S_IDLE) && start && (alucontrol != OP_MUL);
  assign go_mul   = (state == S_IDLE) && start && (alucontrol == OP_MUL);
  assign mul_last = (state == S_MUL) && (cnt == LAST);
  assign busy     = (state == S_MUL);
  // Accumulator value after this cycle's partial-product step.
  assign mul_add  = acc + (mplier[0] ? mcand : '0);

  // Single-cycle ALU: result plus candidate C/V; C/V default to current flags.
  always_comb begin
    sub       = (alucontrol == OP_SUB);
    bop       = sub ? ~b : b;
    sum       = {1'b0, a} + {1'b0, bop} + {{WIDTH{1'b0}}, sub};
    sh        = b[SHW-1:0];
    lsl_idx   = -sh;                 // WIDTH - sh, modulo WIDTH
    rs_idx    = sh - SHW'(1);
    alu_res   = '0;
    alu_c     = aluflags[1];
    alu_v     = aluflags[0];
    alu_valid = 1'b1;
    case (alucontrol)
      OP_ADD, OP_SUB: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = ((a[WIDTH-1] ~^ b[WIDTH-1]) ^ sub) & (a[WIDTH-1] ^ sum[WIDTH-1]);
      end
      OP_AND: alu_res = a & b;
      OP_ORR: alu_res = a | b;
      OP_EOR: alu_res = a ^ b;
      OP_LSL: begin
        alu_res = a << sh;
        if (sh != '0) alu_c = a[lsl_idx];
      end
      OP_LSR: begin
        alu_res = a >> sh;
        if (sh != '0) alu_c = a[rs_idx];
      end
      OP_ASR: begin
        alu_res = WIDTH'($signed(a) >>> sh);
        if (sh != '0) alu_c = a[rs_idx];
      end
      default: alu_valid = 1'b0;     // reserved opcodes (MUL never takes this path)
    endcase
  end

  // Next-state logic: MUL runs WIDTH cycles (cnt 0..WIDTH-1) after launch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (go_mul)   state_nxt = S_MUL;
      S_MUL:   if (mul_last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Datapath: multiplier iteration, result/flag registers and done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      cnt      <= '0;
      mul_sf   <= 1'b0;
      result   <= '0;
      aluflags <= '0;
      done     <= 1'b0;
    end else begin
      done <= go_alu | mul_last;
      if (go_mul) begin
        acc    <= '0;
        mcand  <= a;
        mplier <= b;
        cnt    <= '0;
        mul_sf <= setflags;
      end else if (state == S_MUL) begin
        acc    <= mul_add;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + SHW'(1);
      end
      if (go_alu) begin
        result <= alu_res;
        if (setflags && alu_valid)
          aluflags <= {alu_res[WIDTH-1], ~|alu_res, alu_c, alu_v};
      end else if (mul_last) begin
        result <= mul_add;
        if (mul_sf)
          aluflags <= {mul_add[WIDTH-1], ~|mul_add, aluflags[1:0]};
      end
    end
  end

endmodule
